// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the seven-segment display blocks.
//   DIGIT_A..DIGIT_D : one-hot anode/digit select codes (bit3 = A, bit0 = D)
//   DIGITS_OFF       : all digits dark
//   scan_state_t     : scan sequencer state
//   digit_onehot()   : slot index (0 = A .. 3 = D) to one-hot select
// -----------------------------------------------------------------------------
package display_pkg;

  localparam logic [3:0] DIGIT_A    = 4'b1000;
  localparam logic [3:0] DIGIT_B    = 4'b0100;
  localparam logic [3:0] DIGIT_C    = 4'b0010;
  localparam logic [3:0] DIGIT_D    = 4'b0001;
  localparam logic [3:0] DIGITS_OFF = 4'b0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
    return DIGIT_A >> idx;
  endfunction

endpackage

// File: rtl/slot_counter.sv
// -----------------------------------------------------------------------------
// slot_counter
// Modulo-DIV free-running counter with synchronous clear. Counts 0..DIV-1 and
// wraps to 0.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset (count -> 0)
//   clear_i : synchronous clear; holds the count at 0 while high
//   cnt_o   : current count, $clog2(DIV) bits
//   wrap_o  : high while cnt_o == DIV-1 (the count wraps on the next edge)
// -----------------------------------------------------------------------------
module slot_counter #(
  parameter  int unsigned DIV = 50000,
  localparam int unsigned CW  = $clog2(DIV)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    if (clear_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == LAST);

endmodule

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
// Time-multiplexed scan sequencer for a four-digit seven-segment display.
// Rotates a one-hot digit select A->B->C->D, each slot DIV cycles long, with
// BLANK dead-time cycles (select = 0) at the start of every slot to avoid
// ghosting.
//   clock      : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   enable     : 1 = scan runs, 0 = display dark (returns to IDLE)
//   digit_mask : per-digit show enable, bit3 = A .. bit0 = D
//   displays   : registered one-hot digit select, 0 when blank/idle/masked
//   digit_idx  : registered slot index, 0 = A .. 3 = D
//   frame_done : registered one-cycle pulse when slot D wraps back to A
// -----------------------------------------------------------------------------
module display_scan_controller #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 500
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] digit_mask,
  output logic [3:0] displays,
  output logic [1:0] digit_idx,
  output logic       frame_done
);

  // The parameter BLANK shares its name with the BLANK state, so the package
  // items are imported by name and that state is always package-qualified.
  import display_pkg::scan_state_t;
  import display_pkg::IDLE;
  import display_pkg::SHOW;
  import display_pkg::DIGITS_OFF;
  import display_pkg::digit_onehot;

  localparam int unsigned CW        = $clog2(DIV);
  localparam bit          HAS_BLANK = (BLANK > 0);
  // Count value on the last dead-time cycle of a slot (unused when BLANK = 0).
  localparam logic [CW-1:0] BLANK_LAST = CW'(HAS_BLANK ? BLANK - 1 : 0);
  localparam scan_state_t ENTRY_STATE =
    HAS_BLANK ? display_pkg::BLANK : SHOW;

  scan_state_t   state_q;
  logic [3:0]    displays_q;
  logic [1:0]    digit_idx_q;
  logic          frame_done_q;

  logic [CW-1:0] cnt;
  logic          cnt_wrap;
  logic          cnt_clear;
  logic          blank_done;
  logic [1:0]    next_idx;

  // The counter sits at 0 whenever the scan is stopped, so entering BLANK or
  // SHOW from IDLE always starts a slot at count 0.
  assign cnt_clear  = !enable || (state_q == IDLE);
  assign blank_done = HAS_BLANK && (cnt == BLANK_LAST);
  assign next_idx   = digit_idx_q + 2'd1;

  slot_counter #(
    .DIV (DIV)
  ) u_slot_counter (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .clear_i (cnt_clear),
    .cnt_o   (cnt),
    .wrap_o  (cnt_wrap)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      displays_q   <= DIGITS_OFF;
      digit_idx_q  <= 2'd0;
      frame_done_q <= 1'b0;
    end else if (!enable) begin
      // Abandon the current slot immediately; a later enable restarts at A.
      state_q      <= IDLE;
      displays_q   <= DIGITS_OFF;
      digit_idx_q  <= 2'd0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          state_q     <= ENTRY_STATE;
          displays_q  <= DIGITS_OFF;
          digit_idx_q <= 2'd0;
        end

        display_pkg::BLANK: begin
          if (blank_done) begin
            // Light the digit on the same edge that enters SHOW.
            state_q    <= SHOW;
            displays_q <= digit_onehot(digit_idx_q) & digit_mask;
          end else begin
            displays_q <= DIGITS_OFF;
          end
        end

        SHOW: begin
          if (cnt_wrap) begin
            digit_idx_q  <= next_idx;
            frame_done_q <= (digit_idx_q == 2'd3);
            if (HAS_BLANK) begin
              state_q    <= display_pkg::BLANK;
              displays_q <= DIGITS_OFF;
            end else begin
              displays_q <= digit_onehot(next_idx) & digit_mask;
            end
          end else begin
            displays_q <= digit_onehot(digit_idx_q) & digit_mask;
          end
        end

        default: begin
          state_q     <= IDLE;
          displays_q  <= DIGITS_OFF;
          digit_idx_q <= 2'd0;
        end
      endcase
    end
  end

  assign displays   = displays_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_display_scan_controller
// Drives two controllers from shared enable/mask: one with DIV=8, BLANK=2 and
// one with DIV=4, BLANK=0. Expected outputs come from a time-since-enable
// model: with t cycles elapsed since the enabling edge, the slot is t/DIV,
// the position within it is t%DIV, and the select is lit past the dead time
// using the mask present before the loading edge.
// -----------------------------------------------------------------------------
module tb_display_scan_controller;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic [3:0] digit_mask;

  logic [3:0] disp_a;
  logic [1:0] idx_a;
  logic       fd_a;
  logic [3:0] disp_b;
  logic [1:0] idx_b;
  logic       fd_b;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: scan running flag and cycles since the enabling edge.
  bit run_m = 1'b0;
  int t_m   = 0;

  display_scan_controller #(.DIV(8), .BLANK(2)) u_dut_a (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .digit_mask (digit_mask),
    .displays   (disp_a),
    .digit_idx  (idx_a),
    .frame_done (fd_a)
  );

  display_scan_controller #(.DIV(4), .BLANK(0)) u_dut_b (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .digit_mask (digit_mask),
    .displays   (disp_b),
    .digit_idx  (idx_b),
    .frame_done (fd_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t_m);
    end
  endtask

  function automatic logic [3:0] exp_disp(int div, int blank, bit run, int t, logic [3:0] m);
    logic [3:0] sel;
    int pos;
    if (!run) return 4'b0000;
    pos = t % div;
    // Dead time at slot start; with no dead time, the entry cycle is still dark.
    if (pos < blank || (blank == 0 && t == 0)) return 4'b0000;
    sel = 4'b1000;
    sel = sel >> ((t / div) % 4);
    return sel & m;
  endfunction

  function automatic logic [3:0] exp_idx(int div, bit run, int t);
    if (!run) return 4'd0;
    return 4'((t / div) % 4);
  endfunction

  function automatic logic [3:0] exp_fd(int div, bit run, int t);
    return (run && t > 0 && (t % (4 * div)) == 0) ? 4'd1 : 4'd0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_disp_a"}, disp_a, 4'd0);
    check({tag, "_idx_a"}, {2'b0, idx_a}, 4'd0);
    check({tag, "_fd_a"}, {3'b0, fd_a}, 4'd0);
    check({tag, "_disp_b"}, disp_b, 4'd0);
    check({tag, "_idx_b"}, {2'b0, idx_b}, 4'd0);
    check({tag, "_fd_b"}, {3'b0, fd_b}, 4'd0);
  endtask

  // One clock: capture inputs seen by the edge, advance the model, compare.
  task automatic tick();
    logic [3:0] m;
    bit en;
    m  = digit_mask;
    en = enable;
    @(posedge clock);
    #1;
    if (en) begin
      if (run_m) t_m++;
      else begin
        run_m = 1'b1;
        t_m   = 0;
      end
    end else begin
      run_m = 1'b0;
      t_m   = 0;
    end
    check("disp_a", disp_a, exp_disp(8, 2, run_m, t_m, m));
    check("idx_a", {2'b0, idx_a}, exp_idx(8, run_m, t_m));
    check("fd_a", {3'b0, fd_a}, exp_fd(8, run_m, t_m));
    check("disp_b", disp_b, exp_disp(4, 0, run_m, t_m, m));
    check("idx_b", {2'b0, idx_b}, exp_idx(4, run_m, t_m));
    check("fd_b", {3'b0, fd_b}, exp_fd(4, run_m, t_m));
    // Structural properties independent of slot timing.
    check("onehot_a", {3'b0, $onehot0(disp_a)}, 4'd1);
    check("onehot_b", {3'b0, $onehot0(disp_b)}, 4'd1);
    check("masked_a", disp_a & ~m, 4'd0);
    check("masked_b", disp_b & ~m, 4'd0);
  endtask

  initial begin
    int guard;
    reset_n    = 1'b0;
    enable     = 1'b0;
    digit_mask = 4'b1111;

    // Reset state.
    #12;
    check_all_zero("reset");
    #5 reset_n = 1'b1;

    // Idle with enable low: dark for 50 cycles.
    repeat (50) tick();

    // Full scan with all digits; covers first frame_done at t = 32.
    enable = 1'b1;
    repeat (70) tick();

    // Asynchronous reset mid-scan, between clock edges.
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_rst");
    run_m = 1'b0;
    #1 reset_n = 1'b1;
    repeat (20) tick();

    // Masking: only A and C light.
    digit_mask = 4'b1010;
    repeat (40) tick();
    // Unmask mid-slot-B (DIV=8 instance) during its SHOW phase.
    guard = 0;
    while (!(((t_m / 8) % 4) == 1 && (t_m % 8) == 4) && guard < 100) begin
      tick();
      guard++;
    end
    check("reach_slot_b", {3'b0, guard < 100}, 4'd1);
    digit_mask = 4'b1111;
    repeat (20) tick();

    // Enable drop during slot C SHOW, then immediate re-enable.
    guard = 0;
    while (!(((t_m / 8) % 4) == 2 && (t_m % 8) == 4) && guard < 100) begin
      tick();
      guard++;
    end
    check("reach_slot_c", {3'b0, guard < 100}, 4'd1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    repeat (40) tick();

    // Ten frames of the DIV=8 instance with random mask changes.
    repeat (320) begin
      if ($urandom_range(0, 3) == 0) digit_mask = 4'($urandom);
      tick();
    end

    // Occasional enable glitches under random masks.
    repeat (100) begin
      if ($urandom_range(0, 3) == 0) digit_mask = 4'($urandom);
      enable = ($urandom_range(0, 19) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexed scan sequencer for the four-digit seven-segment display. It generates the one-hot `displays` select that drives the segment multiplexer and the digit anodes, rotating A→B→C→D (`4'b1000`→`4'b0100`→`4'b0010`→`4'b0001`) at a programmable rate. A dead-time blank (`displays = 0`) precedes each digit, so the segment multiplexer outputs 0 and no ghosting occurs. It sits between the system clock and the segment multiplexer/anode drivers.

## Interface
Parameters:
- `DIV`, 50000, clock cycles per digit slot (blank plus show); legal range ≥2.
- `BLANK`, 500, dead-time cycles at the start of each slot; legal range 0 ≤ BLANK < DIV.

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  1 = scan runs; 0 = display dark.
- `digit_mask`  in  4  per-digit show enable; bit3 = A … bit0 = D; 0 keeps that digit dark during its slot.
- `displays`  out  4  registered one-hot digit select, or 0 when blank, idle or masked.
- `digit_idx`  out  2  registered slot index; 0 = A … 3 = D.
- `frame_done`  out  1  registered one-cycle pulse at the start of each new frame.

## Operation
- All outputs are registered. Reset values: `displays = 0`, `digit_idx = 0`, `frame_done = 0`, state IDLE, slot counter 0.
- The slot counter `cnt` has width `$clog2(DIV)`. It counts 0..DIV-1 and runs in both BLANK and SHOW.
- IDLE:
  - `displays = 0`.
  - When `enable = 1`, the next edge loads state BLANK (or SHOW if BLANK = 0), `cnt = 0` and `digit_idx = 0`.
- BLANK:
  - `displays = 0`.
  - When `cnt == BLANK-1`, the next state is SHOW.
- SHOW:
  - Each edge loads `displays = (4'b1000 >> digit_idx) & digit_mask`, so a mask change takes effect one cycle later.
  - When `cnt == DIV-1`, the next edge loads `cnt = 0` and `digit_idx = digit_idx + 1`, with wrap 3→0.
  - The state then returns to BLANK, with `displays = 0`. If BLANK = 0 it stays in SHOW and `displays` takes the next one-hot value directly.
- `frame_done`:
  - Set to 1 on the edge where `digit_idx` wraps 3→0.
  - Cleared on the following edge.
  - Never asserted on the entry from IDLE.
- `enable` deasserted in any state: the next edge loads IDLE, `displays = 0`, `digit_idx = 0`, `cnt = 0`, `frame_done = 0`. There is no completion of the current slot.
- If `enable` falls and rises on consecutive cycles, the scan restarts cleanly from slot A.
- `reset_n` low mid-scan forces the reset values immediately, independent of `clock`.

## Timing
- Slot length is exactly DIV cycles. `displays` is nonzero for DIV-BLANK cycles per slot, and only if the corresponding mask bit is set.
- Frame length is 4·DIV cycles. The `frame_done` period is 4·DIV cycles.
- Start-up latency:
  - `enable` sampled high at edge E0 → BLANK during the cycle after E0.
  - The first nonzero `displays` (digit A) appears after edge E0+BLANK.
  - With BLANK = 0, it appears after edge E0+1.
- `displays` is never more than one-hot. It never changes directly from one nonzero value to a different nonzero value when BLANK > 0.

## Structure
- Shared package `display_pkg`:
  - digit one-hot constants `DIGIT_A = 4'b1000`, `DIGIT_B = 4'b0100`, `DIGIT_C = 4'b0010`, `DIGIT_D = 4'b0001`, `DIGITS_OFF = 4'b0000`;
  - state enum `scan_state_t` {IDLE, BLANK, SHOW}.
- Sub-module `slot_counter`:
  - parameterised modulo-DIV counter with synchronous clear;
  - outputs `cnt` and a `wrap` strobe at DIV-1.
- Also usable by future display blocks (blink, brightness).

## Test plan
- Reset/idle: DIV = 8, BLANK = 2, `enable = 0`, mask `4'b1111` → `displays` stays 0, `digit_idx` 0 and `frame_done` 0 for 50 cycles; assert `reset_n` mid-run → outputs 0 asynchronously.
- Full scan: DIV = 8, BLANK = 2, mask `4'b1111`, `enable` ↑ → per slot 2 cycles of 0 then 6 cycles of 8, then 4, 2, 1; `frame_done` is a one-cycle pulse every 32 cycles, first pulse 32 cycles after the entry into BLANK.
- Masking: mask `4'b1010` → only 8 and 2 appear, slots B and D fully 0; change mask to `4'b1111` mid-slot-B → B lights one cycle later.
- BLANK = 0, DIV = 4 → `displays` sequence 8,8,8,8,4,4,4,4,2,… with no zero gaps.
- Enable drop: deassert `enable` during slot C SHOW → next edge `displays = 0`, `digit_idx = 0`; reassert → restarts at A after BLANK cycles, no spurious `frame_done`.
- One-hot check: across 10 frames with random mask toggles, `displays` is always 0 or one-hot and always ANDed with the mask from the previous cycle.
